timer_sched_wb8: RTL
====================

# timer_sched_wb8

Four-slot alarm scheduler between the CPU's 8-bit Wishbone bus and the millisecond timer. It acts as a Wishbone master to the timer and polls the timer's current-time bytes periodically. It compares the polled time against four software-programmable 32-bit deadlines. It raises per-slot pending flags and a masked interrupt to the CPU.

## Interface
- POLL_CYCLES, 1000, idle cycles inserted between the end of one compare and the start of the next poll; 0 means back-to-back polling.
- I_wb_clk  in  1  clock for all logic; rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_wb_adr  in  5  slave register address.
- I_wb_dat  in  8  slave write data.
- I_wb_stb  in  1  slave strobe.
- I_wb_we  in  1  slave write enable.
- O_wb_ack  out  1  slave acknowledge.
- O_wb_dat  out  8  slave read data.
- O_tmr_adr  out  3  master address to the timer.
- O_tmr_stb  out  1  master strobe to the timer.
- O_tmr_we  out  1  master write enable; always 0.
- O_tmr_dat  out  8  master write data; always 0.
- I_tmr_ack  in  1  timer acknowledge.
- I_tmr_dat  in  8  timer read data.
- O_interrupt  out  1  high while |(pending & enable).

## Operation
- Slave register map:
  - 0..15: slot n deadline, byte k at address 4n+k, little-endian. Read/write.
    - Writing byte 3 sets armed[n].
    - Writing byte 0..2 clears armed[n].
  - 16: pending[3:0]. Read; writing a 1 to a bit clears it.
  - 17: armed[3:0]. Read; writing a 0 to a bit clears it; writing a 1 has no effect.
  - 18: enable[3:0]. Read/write.
  - Bits [7:4] of addresses 16..18 read 0. Unmapped addresses read 0; writes to them are ignored.
- Slave handshake: O_wb_ack <= I_wb_stb every cycle. O_wb_dat and register updates are registered on each strobed cycle.
- Master FSM states: WAIT, RD0, RD1, RD2, RD3, CMP.
  - WAIT: a counter runs from 0 to POLL_CYCLES; then go to RD0.
  - RDk: assert O_tmr_stb with O_tmr_adr=k for exactly one cycle. Keep stb low while waiting for I_tmr_ack. On the ack cycle, capture I_tmr_dat into now[8k+7:8k] and advance to the next state.
    - Single-cycle strobes are mandatory: the timer latches its upper bytes on an address-0 strobe, so a repeated strobe would tear the value.
    - There is no ack timeout.
  - CMP: one cycle. For each slot n with armed[n]=1 and ($signed(now - deadline[n]) >= 0), set pending[n] and clear armed[n]. Go to WAIT.
- Deadline arithmetic is 32-bit modular, so deadlines up to 2^31-1 ms ahead are wrap-safe.
- Simultaneous events:
  - Slave clear of pending[n] and CMP set of pending[n] in the same cycle: set wins.
  - Slave write to slot n in the CMP cycle: the slave write wins for armed[n], and the compare uses the old deadline for pending[n].

## Timing
- Reset values: all outputs 0. Deadlines, now, armed, pending, enable and the counter are 0. FSM is in WAIT.
- Assertion of I_reset_n mid-transaction aborts the transaction immediately and drops O_tmr_stb asynchronously.
- Slave read latency: 1 cycle (data and ack in the same cycle).
- With the timer's 1-cycle ack, each RDk takes 2 cycles. A poll-plus-compare takes 9 cycles, and the poll period is 9+POLL_CYCLES+1 cycles.
- pending and O_interrupt change in the cycle after CMP.
- O_interrupt is combinational from registered pending and enable, so it is glitch-free.

## Configuration
- TIMER_SCHED_SNAPSHOT_EN defined: addresses 20..23 read the last fully captured poll value now[31:0], little-endian, updated at CMP.
- Not defined: no snapshot register is built, and addresses 20..23 read 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset with I_reset_n=0 for 3 cycles, then release: all outputs 0, and the first O_tmr_stb pulse (adr 0) occurs POLL_CYCLES+1 cycles after release.
- Timer model returning now=0x00000100:
  - Write slot 1 deadline 0x000000F0 and enable=0x2: pending=0x2, O_interrupt=1 after the next CMP, and armed[1]=0.
  - Then write 0x2 to address 16: O_interrupt=0.
- Wrap-around: now=0x00000005, slot 0 deadline 0xFFFFFFF0 armed: fires.
  - Deadline 0x00000010 with now=0xFFFFFFF0 must not fire.
- Partial write: write only byte 0 of an armed slot 2 that is already due: armed[2]=0 and there is no pending.
- Master protocol: a timer model with a 3-cycle ack delay sees exactly one stb cycle per address, in the sequence 0,1,2,3. Assert I_reset_n low during RD2, then release: stb stays low and polling restarts at RD0.
- With TIMER_SCHED_SNAPSHOT_EN and now=0xA1B2C3D4: addresses 20..23 read D4, C3, B2, A1. Without the macro, they read 00.

Source files
------------

// File: rtl/timer_sched_wb8.sv
// timer_sched_wb8: four-slot alarm scheduler.
// 8-bit Wishbone slave towards the CPU (deadlines, pending, armed, enable) and
// 8-bit Wishbone master that polls the millisecond timer's four time bytes,
// then compares the polled time against each armed deadline.
// Optional build macro: TIMER_SCHED_SNAPSHOT_EN adds a read-only copy of the
// last fully captured poll value at addresses 20..23.
module timer_sched_wb8 #(
  parameter int POLL_CYCLES = 1000
) (
  input  logic       I_wb_clk,
  input  logic       I_reset_n,
  input  logic [4:0] I_wb_adr,
  input  logic [7:0] I_wb_dat,
  input  logic       I_wb_stb,
  input  logic       I_wb_we,
  output logic       O_wb_ack,
  output logic [7:0] O_wb_dat,
  output logic [2:0] O_tmr_adr,
  output logic       O_tmr_stb,
  output logic       O_tmr_we,
  output logic [7:0] O_tmr_dat,
  input  logic       I_tmr_ack,
  input  logic [7:0] I_tmr_dat,
  output logic       O_interrupt
);

  localparam int CNT_W = (POLL_CYCLES > 0) ? $clog2(POLL_CYCLES + 1) : 1;

  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_RD2  = 3'd3;
  localparam logic [2:0] ST_RD3  = 3'd4;
  localparam logic [2:0] ST_CMP  = 3'd5;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tmr_stb_r;
  logic [2:0]       tmr_adr_r;
  logic [31:0]      now_r;
  logic [31:0]      deadline_r [4];
  logic [3:0]       armed_r;
  logic [3:0]       pending_r;
  logic [3:0]       enable_r;
  logic             wb_ack_r;
  logic [7:0]       wb_dat_r;

  logic             wr_s;
  logic [3:0]       fire_s;
  logic [3:0]       pending_nxt_s;
  logic [3:0]       armed_nxt_s;
  logic [7:0]       rd_data_s;

  // Byte k of a little-endian 32-bit word.
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] k);
    case (k)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  // A deadline is reached when the modular difference now - deadline is non-negative.
  function automatic logic is_due(input logic [31:0] now, input logic [31:0] dl);
    logic [31:0] diff;
    diff = now - dl;
    return ~diff[31];
  endfunction

  assign wr_s        = I_wb_stb & I_wb_we;
  assign O_wb_ack    = wb_ack_r;
  assign O_wb_dat    = wb_dat_r;
  assign O_tmr_stb   = tmr_stb_r;
  assign O_tmr_adr   = tmr_adr_r;
  assign O_tmr_we    = 1'b0;
  assign O_tmr_dat   = 8'h00;
  assign O_interrupt = |(pending_r & enable_r);

  // Poll master: idle count, four single-strobe byte reads, one compare cycle.
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_r   <= ST_WAIT;
      cnt_r     <= '0;
      tmr_stb_r <= 1'b0;
      tmr_adr_r <= 3'd0;
      now_r     <= 32'h0;
    end else begin
      tmr_stb_r <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (cnt_r == CNT_W'(POLL_CYCLES)) begin
            cnt_r     <= '0;
            state_r   <= ST_RD0;
            tmr_stb_r <= 1'b1;
            tmr_adr_r <= 3'd0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RD0, ST_RD1, ST_RD2, ST_RD3: begin
          if (I_tmr_ack) begin
            case (tmr_adr_r[1:0])
              2'd0:    now_r[7:0]   <= I_tmr_dat;
              2'd1:    now_r[15:8]  <= I_tmr_dat;
              2'd2:    now_r[23:16] <= I_tmr_dat;
              default: now_r[31:24] <= I_tmr_dat;
            endcase
            if (state_r == ST_RD3) begin
              state_r <= ST_CMP;
            end else begin
              state_r   <= state_r + 3'd1;
              tmr_stb_r <= 1'b1;
              tmr_adr_r <= tmr_adr_r + 3'd1;
            end
          end
        end
        ST_CMP:  state_r <= ST_WAIT;
        default: state_r <= ST_WAIT;
      endcase
    end
  end

  // Slots that fire in this compare cycle (old deadlines, old armed bits).
  always_comb begin
    fire_s = 4'h0;
    for (int n = 0; n < 4; n++) begin
      fire_s[n] = (state_r == ST_CMP) & armed_r[n] & is_due(now_r, deadline_r[n]);
    end
  end

  // Next pending/armed: compare set beats slave clear; slave slot write beats compare clear.
  always_comb begin
    pending_nxt_s = pending_r;
    armed_nxt_s   = armed_r & ~fire_s;
    if (wr_s && I_wb_adr == 5'd16) begin
      pending_nxt_s = pending_r & ~I_wb_dat[3:0];
    end else begin
      pending_nxt_s = pending_r;
    end
    pending_nxt_s = pending_nxt_s | fire_s;
    if (wr_s && !I_wb_adr[4]) begin
      armed_nxt_s[I_wb_adr[3:2]] = (I_wb_adr[1:0] == 2'd3);
    end else if (wr_s && I_wb_adr == 5'd17) begin
      armed_nxt_s = armed_nxt_s & I_wb_dat[3:0];
    end else begin
      armed_nxt_s = armed_nxt_s;
    end
  end

`ifdef TIMER_SCHED_SNAPSHOT_EN
  logic [31:0] snap_r;

  // Snapshot of the completed poll value, taken at each compare.
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      snap_r <= 32'h0;
    end else if (state_r == ST_CMP) begin
      snap_r <= now_r;
    end else begin
      snap_r <= snap_r;
    end
  end
`endif

  // Slave read multiplexer.
  always_comb begin
    rd_data_s = 8'h00;
    if (!I_wb_adr[4]) begin
      rd_data_s = get_byte(deadline_r[I_wb_adr[3:2]], I_wb_adr[1:0]);
    end else begin
      case (I_wb_adr)
        5'd16:   rd_data_s = {4'h0, pending_r};
        5'd17:   rd_data_s = {4'h0, armed_r};
        5'd18:   rd_data_s = {4'h0, enable_r};
`ifdef TIMER_SCHED_SNAPSHOT_EN
        5'd20, 5'd21, 5'd22, 5'd23: rd_data_s = get_byte(snap_r, I_wb_adr[1:0]);
`endif
        default: rd_data_s = 8'h00;
      endcase
    end
  end

  // Slave registers: ack every strobe, register read data and writes.
  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      wb_ack_r  <= 1'b0;
      wb_dat_r  <= 8'h00;
      armed_r   <= 4'h0;
      pending_r <= 4'h0;
      enable_r  <= 4'h0;
      for (int n = 0; n < 4; n++) begin
        deadline_r[n] <= 32'h0;
      end
    end else begin
      wb_ack_r  <= I_wb_stb;
      armed_r   <= armed_nxt_s;
      pending_r <= pending_nxt_s;
      if (I_wb_stb) begin
        wb_dat_r <= rd_data_s;
      end
      if (wr_s && !I_wb_adr[4]) begin
        case (I_wb_adr[1:0])
          2'd0:    deadline_r[I_wb_adr[3:2]][7:0]   <= I_wb_dat;
          2'd1:    deadline_r[I_wb_adr[3:2]][15:8]  <= I_wb_dat;
          2'd2:    deadline_r[I_wb_adr[3:2]][23:16] <= I_wb_dat;
          default: deadline_r[I_wb_adr[3:2]][31:24] <= I_wb_dat;
        endcase
      end
      if (wr_s && I_wb_adr == 5'd18) begin
        enable_r <= I_wb_dat[3:0];
      end
    end
  end

endmodule
